// File: rtl/riscv_core_rob_multi_if.sv
// ============================================================================
//  Module      : riscv_core_rob_multi_if
//  Description : Allocation / completion / commit bundle between the issue
//                stage, execution units and the reorder buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_core_rob_multi_if #(
    parameter int DEPTH   = 16,
    parameter int SLOT_W  = 4,
    parameter int RADDR_W = 5,
    parameter int NFILL   = 2
);
    // Allocation
    logic                      rob_alloc_req_val;
    logic                      rob_alloc_req_rdy;
    logic                      rob_alloc_req_wen;
    logic [RADDR_W-1:0]        rob_alloc_req_preg;
    logic [SLOT_W-1:0]         rob_alloc_resp_slot;
    // Completion
    logic [NFILL-1:0]          rob_fill_val;
    logic [NFILL*SLOT_W-1:0]   rob_fill_slot;
    logic [NFILL-1:0]          rob_fill_exc;
    // Squash
    logic                      rob_flush_val;
    // Commit
    logic                      rob_commit0_val;
    logic                      rob_commit1_val;
    logic                      rob_commit0_wen;
    logic                      rob_commit1_wen;
    logic [SLOT_W-1:0]         rob_commit0_slot;
    logic [SLOT_W-1:0]         rob_commit1_slot;
    logic [RADDR_W-1:0]        rob_commit0_rf_waddr;
    logic [RADDR_W-1:0]        rob_commit1_rf_waddr;
    logic                      rob_commit_exc;
    // Status
    logic [SLOT_W:0]           rob_count;
    logic                      rob_empty;
    logic                      rob_full;

    // Issue / execution side
    modport master (
        output rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        output rob_fill_val, rob_fill_slot, rob_fill_exc, rob_flush_val,
        input  rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_commit0_val, rob_commit1_val, rob_commit0_wen, rob_commit1_wen,
        input  rob_commit0_slot, rob_commit1_slot,
        input  rob_commit0_rf_waddr, rob_commit1_rf_waddr, rob_commit_exc,
        input  rob_count, rob_empty, rob_full
    );

    // Reorder buffer side
    modport slave (
        input  rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        input  rob_fill_val, rob_fill_slot, rob_fill_exc, rob_flush_val,
        output rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_commit0_val, rob_commit1_val, rob_commit0_wen, rob_commit1_wen,
        output rob_commit0_slot, rob_commit1_slot,
        output rob_commit0_rf_waddr, rob_commit1_rf_waddr, rob_commit_exc,
        output rob_count, rob_empty, rob_full
    );
endinterface

`default_nettype wire

// File: rtl/riscv_core_rob_multi.sv
// ============================================================================
//  Module      : riscv_core_rob_multi
//  Description : Reorder buffer. In-order allocation, out-of-order completion
//                on NFILL ports, in-order retirement of up to two entries per
//                cycle, flush and precise exception squash.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_rob_multi #(
    parameter int DEPTH   = 16,
    parameter int SLOT_W  = 4,
    parameter int RADDR_W = 5,
    parameter int NFILL   = 2
) (
    input  wire logic                    clk_i,
    input  wire logic                    reset_ni,
    riscv_core_rob_multi_if.slave        rob
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SLOT_W:0]       head_q, head_d;
    logic [SLOT_W:0]       tail_q, tail_d;
    logic [DEPTH-1:0]      val_q,  val_d;
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [DEPTH-1:0]      exc_q,  exc_d;
    logic [DEPTH-1:0]      wen_q,  wen_d;
    logic [RADDR_W-1:0]    waddr_q [DEPTH];
    logic [RADDR_W-1:0]    waddr_d [DEPTH];

    // ------------------------------------------------------------------
    // Combinational status
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]     w_h0, w_h1, w_tail;
    logic [SLOT_W:0]       w_count;
    logic                  w_full, w_empty, w_rdy, w_alloc;
    logic                  w_ready0, w_ready1;
    logic                  w_commit0, w_commit1, w_cexc;

    assign w_h0    = head_q[SLOT_W-1:0];
    assign w_h1    = w_h0 + {{(SLOT_W-1){1'b0}}, 1'b1};  // wraps with the ring
    assign w_tail  = tail_q[SLOT_W-1:0];
    assign w_count = tail_q - head_q;
    assign w_full  = (head_q[SLOT_W] != tail_q[SLOT_W]) && (w_h0 == w_tail);
    assign w_empty = (head_q == tail_q);

    // Ready depends on registered occupancy only: a commit this cycle does
    // not open a slot until the next cycle.
    assign w_rdy   = !w_full && !rob.rob_flush_val;
    assign w_alloc = rob.rob_alloc_req_val && w_rdy;

    assign w_ready0  = val_q[w_h0] && !pend_q[w_h0];
    assign w_ready1  = val_q[w_h1] && !pend_q[w_h1];
    assign w_commit0 = w_ready0 && !rob.rob_flush_val;
    assign w_cexc    = w_commit0 && exc_q[w_h0];
    // The second port only retires behind a clean head, so an exception is
    // always the last instruction to retire.
    assign w_commit1 = w_commit0 && !exc_q[w_h0] && w_ready1 && !exc_q[w_h1]
                       && (w_count >= (SLOT_W+1)'(2));

    // ------------------------------------------------------------------
    // Outputs; slot/address fields read zero when their port is idle
    // ------------------------------------------------------------------
    assign rob.rob_alloc_req_rdy    = w_rdy;
    assign rob.rob_alloc_resp_slot  = w_tail;
    assign rob.rob_commit0_val      = w_commit0;
    assign rob.rob_commit1_val      = w_commit1;
    assign rob.rob_commit_exc       = w_cexc;
    assign rob.rob_commit0_wen      = w_commit0 && !exc_q[w_h0] && wen_q[w_h0];
    assign rob.rob_commit1_wen      = w_commit1 && wen_q[w_h1];
    assign rob.rob_commit0_slot     = w_commit0 ? w_h0 : '0;
    assign rob.rob_commit1_slot     = w_commit1 ? w_h1 : '0;
    assign rob.rob_commit0_rf_waddr = w_commit0 ? waddr_q[w_h0] : '0;
    assign rob.rob_commit1_rf_waddr = w_commit1 ? waddr_q[w_h1] : '0;
    assign rob.rob_count            = w_count;
    assign rob.rob_empty            = w_empty;
    assign rob.rob_full             = w_full;

    // Next-state: squash, else fills, retirement and allocation together
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        val_d   = val_q;
        pend_d  = pend_q;
        exc_d   = exc_q;
        wen_d   = wen_q;
        for (int i = 0; i < DEPTH; i++) begin
            waddr_d[i] = waddr_q[i];
        end

        if (rob.rob_flush_val || w_cexc) begin
            // Flush and exception retirement both empty the ring.
            head_d = '0;
            tail_d = '0;
            val_d  = '0;
            pend_d = '0;
            exc_d  = '0;
        end else begin
            // Eligibility uses registered flags so that several ports hitting
            // one slot all apply; the highest port lands last and wins.
            for (int k = 0; k < NFILL; k++) begin
                if (rob.rob_fill_val[k]
                    && val_q[rob.rob_fill_slot[k*SLOT_W +: SLOT_W]]
                    && pend_q[rob.rob_fill_slot[k*SLOT_W +: SLOT_W]]) begin
                    pend_d[rob.rob_fill_slot[k*SLOT_W +: SLOT_W]] = 1'b0;
                    exc_d[rob.rob_fill_slot[k*SLOT_W +: SLOT_W]]  = rob.rob_fill_exc[k];
                end
            end

            if (w_commit0) begin
                val_d[w_h0] = 1'b0;
            end
            if (w_commit1) begin
                val_d[w_h1] = 1'b0;
            end
            head_d = head_q + {{SLOT_W{1'b0}}, w_commit0} + {{SLOT_W{1'b0}}, w_commit1};

            // The tail slot is never a committing slot unless the ring is
            // full, in which case no allocation happens.
            if (w_alloc) begin
                val_d[w_tail]   = 1'b1;
                pend_d[w_tail]  = 1'b1;
                exc_d[w_tail]   = 1'b0;
                wen_d[w_tail]   = rob.rob_alloc_req_wen;
                waddr_d[w_tail] = rob.rob_alloc_req_preg;
                tail_d          = tail_q + {{SLOT_W{1'b0}}, 1'b1};
            end
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q <= '0;
            tail_q <= '0;
            val_q  <= '0;
            pend_q <= '0;
            exc_q  <= '0;
            wen_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            val_q  <= val_d;
            pend_q <= pend_d;
            exc_q  <= exc_d;
            wen_q  <= wen_d;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
            end
        end
    end

endmodule

`default_nettype wire
